// File: rtl/fft_frame_loader.sv
// Streaming complex-sample to parallel-frame loader for the FFT core.
// Two ping-pong banks: one fills from the stream while the other is presented.
module fft_frame_loader #(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [W:0]         in_re,
    input  logic signed [W:0]         in_im,
    input  logic                      in_last,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic [N-1:0][1:0][W:0]    x_out,
    output logic                      frame_err
);

    localparam int IW = (N > 2) ? $clog2(N) : 1;

    typedef logic [N-1:0][1:0][W:0] frame_t;

    frame_t [1:0] bank_q, bank_d;
    logic   [1:0] err_q, err_d;
    logic   [1:0] full_q, full_d;
    logic         wr_bank_q, wr_bank_d;
    logic         rd_bank_q, rd_bank_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;

    logic accept;
    logic consume;
    logic last_slot;
    logic close;

    assign in_ready    = !full_q[wr_bank_q];
    assign frame_valid = full_q[rd_bank_q];
    assign x_out       = bank_q[rd_bank_q];
    assign frame_err   = err_q[rd_bank_q];

    assign accept    = in_valid && in_ready;
    assign consume   = frame_valid && frame_ready;
    assign last_slot = (wr_idx_q == IW'(N - 1));
    assign close     = accept && (last_slot || in_last);

    always_comb begin
        bank_d    = bank_q;
        err_d     = err_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;

        if (accept) begin
            bank_d[wr_bank_q][wr_idx_q][0] = in_re;
            bank_d[wr_bank_q][wr_idx_q][1] = in_im;
            if (close) begin
                // Short frames are zero-padded so stale samples never leak.
                for (int k = 0; k < N; k++) begin
                    if (k > int'(wr_idx_q)) begin
                        bank_d[wr_bank_q][k] = '0;
                    end
                end
                err_d[wr_bank_q]  = !(last_slot && in_last);
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_idx_d          = '0;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end

        // Close never targets the presented full bank, so both may apply.
        if (consume) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q    <= '0;
            err_q     <= '0;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
        end else begin
            bank_q    <= bank_d;
            err_q     <= err_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader with a frame scoreboard.
// Expected frames are queued on close and checked when consumed.
module tb_fft_frame_loader;

    localparam int N = 4;
    localparam int W = 32;

    typedef logic [N-1:0][1:0][W:0] frame_t;
    localparam int FB = $bits(frame_t);

    typedef struct {
        frame_t d;
        logic   e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       frame_ready = 1'b0;
    logic [W:0] in_re = '0;
    logic [W:0] in_im = '0;
    logic       in_ready;
    logic       frame_valid;
    logic       frame_err;
    frame_t     x_out;

    exp_t   q[$];
    frame_t cur = '0;
    int     idx = 0;
    int     tests = 0;
    int     fails = 0;

    fft_frame_loader #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_re       (in_re),
        .in_im       (in_im),
        .in_last     (in_last),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .x_out       (x_out),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [FB-1:0] obs,
                       input logic [FB-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && frame_valid && frame_ready) begin
            chk("frame_expected", FB'(q.size() != 0), FB'(1));
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("frame_data", x_out, e.d);
                chk("frame_err", FB'(frame_err), FB'(e.e));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_accept(input logic [W:0] re, input logic [W:0] im,
                                input logic last);
        cur[idx][0] = re;
        cur[idx][1] = im;
        if (last || idx == N - 1) begin
            q.push_back('{d: cur, e: !(idx == N - 1 && last)});
            cur = '0;
            idx = 0;
        end else begin
            idx++;
        end
    endtask

    task automatic send(input logic [W:0] re, input logic [W:0] im,
                        input logic last);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        in_last  = last;
        while (!in_ready && guard < 100) begin
            cyc(1);
            guard++;
        end
        if (guard >= 100) begin
            chk("ready_timeout", FB'(in_ready), FB'(1));
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_accept(re, im, last);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        frame_ready = 1'b1;
        while (q.size() != 0 && guard < 50) begin
            cyc(1);
            guard++;
        end
        chk("drain", FB'(q.size()), FB'(0));
    endtask

    initial begin
        logic [W:0] v;

        #12;
        chk("rst_fv", FB'(frame_valid), FB'(0));
        chk("rst_ready", FB'(in_ready), FB'(1));
        chk("rst_x", x_out, FB'(0));
        chk("rst_err", FB'(frame_err), FB'(0));
        rst_n = 1'b1;
        cyc(2);
        chk("post_rst_fv", FB'(frame_valid), FB'(0));

        // clean frame, consumer always ready
        frame_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            v = (W + 1)'(k + 1) << 16;
            send(v, -v, k == N - 1);
        end
        chk("t1_latency", FB'(frame_valid), FB'(1));
        chk("t1_err", FB'(frame_err), FB'(0));
        chk("t1_x0_re", FB'(x_out[0][0]), FB'(33'h0_0001_0000));
        chk("t1_x3_im", FB'(x_out[3][1]), FB'(33'h1_FFFC_0000));
        cyc(1);
        chk("t1_one_cycle", FB'(frame_valid), FB'(0));

        // fill both banks with no consumer
        frame_ready = 1'b0;
        for (int k = 0; k < 2 * N; k++) begin
            v = (W + 1)'(k * 16 + 5);
            send(v, ~v, k == N - 1 || k == 2 * N - 1);
        end
        chk("t2_ready_low", FB'(in_ready), FB'(0));
        chk("t2_fv", FB'(frame_valid), FB'(1));
        for (int c = 0; c < 3; c++) begin
            chk("t2_hold", x_out, q[0].d);
            cyc(1);
        end
        frame_ready = 1'b1;
        cyc(1);
        frame_ready = 1'b0;
        chk("t2_switch", x_out, q[0].d);
        chk("t2_ready_back", FB'(in_ready), FB'(1));
        chk("t2_fv_still", FB'(frame_valid), FB'(1));
        for (int k = 2 * N; k < 3 * N; k++) begin
            v = (W + 1)'(k * 16 + 5);
            send(v, ~v, k == 3 * N - 1);
        end
        drain();

        // early last with an idle gap mid-frame
        send(33'h0_0001_0000, 33'h0_0002_0000, 1'b0);
        cyc(2);
        send(33'h0_0003_0000, 33'h0_0004_0000, 1'b1);
        chk("t3_fv", FB'(frame_valid), FB'(1));
        chk("t3_err", FB'(frame_err), FB'(1));
        chk("t3_x1_re", FB'(x_out[1][0]), FB'(33'h0_0003_0000));
        chk("t3_x2_zero", FB'(x_out[2]), FB'(0));
        chk("t3_x3_zero", FB'(x_out[3]), FB'(0));
        for (int k = 0; k < N; k++) begin
            send(33'(k + 100), 33'(k + 200), k == N - 1);
        end
        chk("t3_clean_err", FB'(frame_err), FB'(0));
        drain();

        // missing last
        for (int k = 0; k < N; k++) begin
            send(33'(k + 7), 33'(k + 9), 1'b0);
        end
        chk("t4_err", FB'(frame_err), FB'(1));
        drain();

        // extremes
        for (int k = 0; k < N; k++) begin
            send(33'h1_0000_0000, 33'h0_FFFF_FFFF, k == N - 1);
        end
        chk("t5_re", FB'(x_out[0][0]), FB'(33'h1_0000_0000));
        chk("t5_im", FB'(x_out[N-1][1]), FB'(33'h0_FFFF_FFFF));
        drain();

        // reset during presentation and mid-fill
        frame_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            send(33'(k + 50), 33'(k + 60), k == N - 1);
        end
        send(33'h0_DEAD_0000, 33'h0_BEEF_0000, 1'b0);
        send(33'h0_0BAD_0000, 33'h0_0F00_0000, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_fv", FB'(frame_valid), FB'(0));
        chk("t6_rst_ready", FB'(in_ready), FB'(1));
        chk("t6_rst_x", x_out, FB'(0));
        cyc(2);
        chk("t6_rst_fv2", FB'(frame_valid), FB'(0));
        q.delete();
        cur = '0;
        idx = 0;
        rst_n = 1'b1;
        cyc(1);
        frame_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            send(33'(k + 300), 33'(k + 400), k == N - 1);
        end
        chk("t6_x0", FB'(x_out[0][0]), FB'(33'd300));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
